// File: rtl/y86_pkg.sv
// rtl/y86_pkg.sv - Y86 instruction codes, status encodings and aligner state shared by the fetch front end.
package y86_pkg;

  localparam int MAX_INSTR_BYTES = 10;
  localparam int INSTR_W         = 8 * MAX_INSTR_BYTES;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [1:0] STAT_AOK = 2'd0;
  localparam logic [1:0] STAT_HLT = 2'd1;
  localparam logic [1:0] STAT_ADR = 2'd2;
  localparam logic [1:0] STAT_INS = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FIRST,
    ST_STREAM,
    ST_PRESENT,
    ST_HALT
  } align_state_e;

endpackage

// File: rtl/y86_ilen_decode.sv
// rtl/y86_ilen_decode.sv - Combinational instruction length decode from the first instruction byte.
module y86_ilen_decode
  import y86_pkg::*;
(
  input  logic [7:0] byte0,
  output logic [3:0] len,
  output logic       ins_err
);

  always_comb begin
    len     = 4'd1;
    ins_err = 1'b0;
    unique case (byte0[7:4])
      I_HALT:                              ins_err = (byte0[3:0] != 4'h0);
      I_NOP, I_RET:                        len = 4'd1;
      I_RRMOVQ, I_OPQ, I_PUSHQ, I_POPQ:    len = 4'd2;
      I_JXX, I_CALL:                       len = 4'd9;
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ:        len = 4'd10;
      default:                             ins_err = 1'b1;
    endcase
  end

endmodule

// File: rtl/y86_instr_aligner.sv
// rtl/y86_instr_aligner.sv - Byte-serial instruction fetch and alignment ahead of the Y86 fetch stage.
// Optional address bound check against IMEM_BYTES enabled by Y86_IMEM_BOUND_CHECK_EN.
module y86_instr_aligner
  import y86_pkg::*;
#(
  parameter int IMEM_BYTES = 1024,
  parameter int PC_W       = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pc_load,
  input  logic [PC_W-1:0]   pc_in,
  output logic              imem_rd_en,
  output logic [PC_W-1:0]   imem_addr,
  input  logic [7:0]        imem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [0:INSTR_W-1] out_instr,
  output logic [PC_W-1:0]   out_pc,
  output logic [PC_W-1:0]   out_valp,
  output logic [3:0]        out_len,
  output logic [1:0]        out_stat,
  output logic              halted
);

  align_state_e       state_q, state_d;
  logic [PC_W-1:0]    base_q, base_d;
  logic [3:0]         len_q, len_d;
  logic [1:0]         stat_q, stat_d;
  logic [0:INSTR_W-1] instr_q, instr_d;
  logic [3:0]         k_q, k_d;
  logic               halted_q, halted_d;

  logic               restart;
  logic               req;
  logic [PC_W-1:0]    req_addr;
  logic [3:0]         req_cnt;
  logic [3:0]         dec_len;
  logic               dec_ins;

  y86_ilen_decode u_ilen_decode (
    .byte0   (imem_rdata),
    .len     (dec_len),
    .ins_err (dec_ins)
  );

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    len_d      = len_q;
    stat_d     = stat_q;
    instr_d    = instr_q;
    k_d        = k_q;
    halted_d   = halted_q;
    restart    = 1'b0;
    req        = 1'b0;
    req_addr   = '0;
    req_cnt    = 4'd0;
    imem_rd_en = 1'b0;
    imem_addr  = '0;

    case (state_q)
      ST_IDLE: restart = pc_load;
      ST_FIRST: begin
        if (pc_load) begin
          restart = 1'b1;
        end else begin
          instr_d[0:7] = imem_rdata;
          len_d        = dec_len;
          if (dec_ins) stat_d = STAT_INS;
          else if (imem_rdata[7:4] == I_HALT) stat_d = STAT_HLT;
          if (dec_len > 4'd1 && !dec_ins) begin
            state_d  = ST_STREAM;
            k_d      = 4'd1;
            req      = 1'b1;
            req_addr = base_q + PC_W'(1);
            req_cnt  = 4'd1;
          end else begin
            state_d = ST_PRESENT;
          end
        end
      end
      ST_STREAM: begin
        if (pc_load) begin
          restart = 1'b1;
        end else begin
          instr_d[{k_q, 3'b000} +: 8] = imem_rdata;
          if (k_q + 4'd1 < len_q) begin
            k_d      = k_q + 4'd1;
            req      = 1'b1;
            req_addr = base_q + PC_W'(k_q + 4'd1);
            req_cnt  = k_q + 4'd1;
          end else begin
            state_d = ST_PRESENT;
          end
        end
      end
      ST_PRESENT: begin
        if (out_ready) begin
          if (stat_q == STAT_AOK) begin
            if (pc_load) restart = 1'b1;
            else state_d = ST_IDLE;
          end else begin
            state_d  = ST_HALT;
            halted_d = 1'b1;
          end
        end
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase

    // Any restart discards the partial instruction; the byte returning now belongs to the old fetch.
    if (restart) begin
      base_d   = pc_in;
      instr_d  = '0;
      k_d      = 4'd0;
      len_d    = 4'd1;
      stat_d   = STAT_AOK;
      state_d  = ST_FIRST;
      req      = 1'b1;
      req_addr = pc_in;
      req_cnt  = 4'd0;
    end

    if (req) begin
`ifdef Y86_IMEM_BOUND_CHECK_EN
      if (req_addr >= PC_W'(IMEM_BYTES)) begin
        state_d = ST_PRESENT;
        stat_d  = STAT_ADR;
        len_d   = (req_cnt == 4'd0) ? 4'd1 : req_cnt;
      end else begin
        imem_rd_en = 1'b1;
        imem_addr  = req_addr;
      end
`else
      imem_rd_en = 1'b1;
      imem_addr  = req_addr;
`endif
    end
  end

`ifndef Y86_IMEM_BOUND_CHECK_EN
  logic unused_bound;
  assign unused_bound = ^{IMEM_BYTES, req_cnt};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      base_q   <= '0;
      len_q    <= 4'd0;
      stat_q   <= STAT_AOK;
      instr_q  <= '0;
      k_q      <= 4'd0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      len_q    <= len_d;
      stat_q   <= stat_d;
      instr_q  <= instr_d;
      k_q      <= k_d;
      halted_q <= halted_d;
    end
  end

  assign out_valid = (state_q == ST_PRESENT);
  assign out_instr = instr_q;
  assign out_pc    = base_q;
  assign out_len   = len_q;
  assign out_stat  = stat_q;
  assign out_valp  = base_q + PC_W'(len_q);
  assign halted    = halted_q;

endmodule

// File: tb/tb_y86_instr_aligner.sv
// tb/tb_y86_instr_aligner.sv - Directed vector bench for y86_instr_aligner with a one-cycle-latency byte memory.
module tb_y86_instr_aligner;
  import y86_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        pc_load;
  logic [63:0] pc_in;
  logic        imem_rd_en;
  logic [63:0] imem_addr;
  logic [7:0]  imem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [0:79] out_instr;
  logic [63:0] out_pc;
  logic [63:0] out_valp;
  logic [3:0]  out_len;
  logic [1:0]  out_stat;
  logic        halted;

  always #5 clk = ~clk;

  y86_instr_aligner #(.IMEM_BYTES(1024), .PC_W(64)) dut (
    .clk        (clk),
    .rst        (rst),
    .pc_load    (pc_load),
    .pc_in      (pc_in),
    .imem_rd_en (imem_rd_en),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_instr  (out_instr),
    .out_pc     (out_pc),
    .out_valp   (out_valp),
    .out_len    (out_len),
    .out_stat   (out_stat),
    .halted     (halted)
  );

  logic [7:0]  mem [0:2047];
  logic [63:0] rd_log [$];

  always @(posedge clk) begin
    imem_rdata <= imem_rd_en ? mem[imem_addr[10:0]] : 8'hEE;
    if (imem_rd_en) rd_log.push_back(imem_addr);
  end

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit reads_ok(input logic [63:0] base, input int n);
    logic [63:0] a;
    if (rd_log.size() != n) return 1'b0;
    for (int i = 0; i < n; i++) begin
      a = base + 64'(i);
      if (rd_log[i] !== a) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic do_reset();
    rst = 1'b1; pc_load = 1'b0; out_ready = 1'b0; pc_in = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic load_code(input logic [63:0] pc, input logic [0:79] code, input int n);
    logic [63:0] a;
    for (int i = 0; i < n; i++) begin
      a = pc + 64'(i);
      mem[a[10:0]] = code[8*i +: 8];
    end
  endtask

  task automatic start(input logic [63:0] pc);
    pc_load = 1'b1; pc_in = pc;
    @(negedge clk);
    pc_load = 1'b0;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 1;
    while (!out_valid && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  typedef struct {
    logic [63:0] pc;
    logic [0:79] code;
    logic [3:0]  len;
    logic [63:0] valp;
    logic [1:0]  stat;
  } vec_t;

  vec_t tv [8];
  int   nv;

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int cyc;
    bit bad;

    for (int i = 0; i < 2048; i++) mem[i] = 8'hC3 ^ 8'(i);

    tv[0] = '{64'h10,  80'h30F20A00000000000000, 4'd10, 64'h1A,  STAT_AOK};
    tv[1] = '{64'h04,  80'h00000000000000000000, 4'd1,  64'h05,  STAT_HLT};
    tv[2] = '{64'h30,  80'hF0000000000000000000, 4'd1,  64'h31,  STAT_INS};
    tv[3] = '{64'h100, 80'h80112233445566778800, 4'd9,  64'h109, STAT_AOK};
    tv[4] = '{64'h08,  80'h10000000000000000000, 4'd1,  64'h09,  STAT_AOK};
    tv[5] = '{64'h50,  80'h01000000000000000000, 4'd1,  64'h51,  STAT_INS};
    tv[6] = '{64'h60,  80'hB0F00000000000000000, 4'd2,  64'h62,  STAT_AOK};
    tv[7] = '{64'hFFFF_FFFF_FFFF_FFFF, 80'h20010000000000000000, 4'd2, 64'h1, STAT_AOK};
`ifdef Y86_IMEM_BOUND_CHECK_EN
    nv = 7;
`else
    nv = 8;
`endif

    do_reset();
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_rd_en", imem_rd_en, 1'b0);
    chk("rst_instr", out_instr, 80'h0);
    chk("rst_pc", out_pc, 64'h0);
    chk("rst_valp", out_valp, 64'h0);
    chk("rst_len", out_len, 4'd0);
    chk("rst_stat", out_stat, 2'd0);
    chk("rst_halted", halted, 1'b0);

    for (int v = 0; v < nv; v++) begin
      do_reset();
      load_code(tv[v].pc, tv[v].code, int'(tv[v].len));
      rd_log.delete();
      start(tv[v].pc);
      wait_valid(cyc);
      chk($sformatf("v%0d_latency", v), cyc, int'(tv[v].len) + 1);
      chk($sformatf("v%0d_instr", v), out_instr, tv[v].code);
      chk($sformatf("v%0d_len", v), out_len, tv[v].len);
      chk($sformatf("v%0d_pc", v), out_pc, tv[v].pc);
      chk($sformatf("v%0d_valp", v), out_valp, tv[v].valp);
      chk($sformatf("v%0d_stat", v), out_stat, tv[v].stat);
      chk($sformatf("v%0d_reads", v), reads_ok(tv[v].pc, int'(tv[v].len)), 1'b1);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      rd_log.delete();
      chk($sformatf("v%0d_valid_after", v), out_valid, 1'b0);
      chk($sformatf("v%0d_halted", v), halted, tv[v].stat != STAT_AOK);
      repeat (2) @(negedge clk);
      chk($sformatf("v%0d_idle_reads", v), rd_log.size(), 0);
      if (tv[v].stat != STAT_AOK) begin
        start(tv[v].pc);
        repeat (2) @(negedge clk);
        chk($sformatf("v%0d_halt_reads", v), rd_log.size(), 0);
        chk($sformatf("v%0d_halt_valid", v), out_valid, 1'b0);
      end
    end

    // Back-pressure: result held stable, pc_load ignored while waiting.
    do_reset();
    load_code(64'h0, 80'h60230000000000000000, 2);
    load_code(64'h8, 80'h10000000000000000000, 1);
    rd_log.delete();
    start(64'h0);
    wait_valid(cyc);
    chk("bp_latency", cyc, 3);
    rd_log.delete();
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin pc_load = 1'b1; pc_in = 64'h200; end
      @(negedge clk);
      pc_load = 1'b0;
      chk($sformatf("bp_valid_%0d", i), out_valid, 1'b1);
      chk($sformatf("bp_instr_%0d", i), out_instr, 80'h60230000000000000000);
      chk($sformatf("bp_pc_%0d", i), out_pc, 64'h0);
      chk($sformatf("bp_len_%0d", i), out_len, 4'd2);
    end
    chk("bp_ignored_load_reads", rd_log.size(), 0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    rd_log.delete();
    chk("bp_accepted", out_valid, 1'b0);
    chk("bp_not_halted", halted, 1'b0);
    repeat (3) @(negedge clk);
    chk("bp_idle_reads", rd_log.size(), 0);

    // Accept together with pc_load restarts immediately.
    start(64'h0);
    wait_valid(cyc);
    rd_log.delete();
    out_ready = 1'b1; pc_load = 1'b1; pc_in = 64'h8;
    @(negedge clk);
    out_ready = 1'b0; pc_load = 1'b0;
    chk("rs_read_same_cycle", reads_ok(64'h8, 1), 1'b1);
    wait_valid(cyc);
    chk("rs_latency", cyc, 2);
    chk("rs_pc", out_pc, 64'h8);
    chk("rs_instr", out_instr, 80'h10000000000000000000);
    chk("rs_stat", out_stat, STAT_AOK);

    // Abort a jXX mid-stream and restart at 0x40.
    do_reset();
    load_code(64'h20, 80'h70010203040506070800, 9);
    load_code(64'h40, 80'h61450000000000000000, 2);
    rd_log.delete();
    start(64'h20);
    bad = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (out_valid) bad = 1'b1;
    end
    pc_load = 1'b1; pc_in = 64'h40;
    @(negedge clk);
    pc_load = 1'b0;
    if (out_valid) bad = 1'b1;
    wait_valid(cyc);
    chk("ab_no_valid_old", bad, 1'b0);
    chk("ab_latency", cyc, 3);
    chk("ab_pc", out_pc, 64'h40);
    chk("ab_instr", out_instr, 80'h61450000000000000000);
    chk("ab_len", out_len, 4'd2);
    chk("ab_valp", out_valp, 64'h42);
    chk("ab_reads", (rd_log.size() == 6) && (rd_log[0] == 64'h20) && (rd_log[3] == 64'h23)
                    && (rd_log[4] == 64'h40) && (rd_log[5] == 64'h41), 1'b1);

    // Asynchronous reset in the middle of a stream.
    do_reset();
    load_code(tv[0].pc, tv[0].code, 10);
    start(tv[0].pc);
    repeat (3) @(negedge clk);
    chk("ar_streaming", imem_rd_en, 1'b1);
    rst = 1'b1;
    #1;
    chk("ar_rd_en", imem_rd_en, 1'b0);
    chk("ar_pc", out_pc, 64'h0);
    chk("ar_instr", out_instr, 80'h0);
    chk("ar_len", out_len, 4'd0);
    chk("ar_valid", out_valid, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    rd_log.delete();
    bad = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid) bad = 1'b1;
    end
    chk("ar_no_valid", bad, 1'b0);
    chk("ar_no_reads", rd_log.size(), 0);

`ifdef Y86_IMEM_BOUND_CHECK_EN
    do_reset();
    load_code(64'd1020, 80'h50120102030405060708, 10);
    rd_log.delete();
    start(64'd1020);
    wait_valid(cyc);
    chk("adr_latency", cyc, 5);
    chk("adr_stat", out_stat, STAT_ADR);
    chk("adr_len", out_len, 4'd4);
    chk("adr_valp", out_valp, 64'd1024);
    chk("adr_instr", out_instr, 80'h50120102000000000000);
    chk("adr_reads", reads_ok(64'd1020, 4), 1'b1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/y86_instr_aligner.md
Name: y86_instr_aligner

Overview:
- Front end of the sequential Y86 core; sits directly upstream of the fetch stage.
- Reads the byte-wide instruction memory one byte per cycle and determines the instruction length from the icode nibble.
- Assembles the bytes into a 10-byte, big-endian-indexed instruction word, tagged with PC, valP, length and status.
- Hands the result to fetch over a valid/ready handshake. The next fetch starts only when pc_update loads a new PC.

Parameters:
- IMEM_BYTES, 1024: instruction memory size in bytes; used only by the bound check.
- PC_W, 64: width of PC and memory address.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- pc_load  in  1  start or restart fetch at pc_in (from pc_update).
- pc_in  in  PC_W  next PC.
- imem_rd_en  out  1  byte read strobe.
- imem_addr  out  PC_W  byte address.
- imem_rdata  in  8  read data; valid exactly 1 cycle after imem_rd_en.
- out_valid  out  1  assembled instruction available.
- out_ready  in  1  fetch accepts.
- out_instr  out  [0:79]  byte0 at bits 0:7, byte k at bits 8k:8k+7; unfetched bytes are 0.
- out_pc  out  PC_W  address of byte0.
- out_valp  out  PC_W  out_pc + out_len (mod 2^PC_W).
- out_len  out  4  1, 2, 9 or 10.
- out_stat  out  2  0 AOK, 1 HLT, 2 ADR, 3 INS.
- halted  out  1  sticky; set after a HLT/ADR/INS instruction is accepted.

Behaviour:
- Reset, applied asynchronously: state IDLE. All outputs 0, out_instr 0, halted 0.
- States: IDLE, FIRST, STREAM, PRESENT, HALT.
- IDLE: on pc_load, issue a read at pc_in in the same cycle and latch base=pc_in; go to FIRST.
- FIRST: byte0 arrives. Length comes from icode = byte0[7:4]:
  - len 1: 0, 1, 9.
  - len 2: 2, 6, A, B.
  - len 9: 7, 8.
  - len 10: 3, 4, 5.
  - icode C–F: INS, len 1.
  - If len>1, issue base+1 in this cycle and go to STREAM; otherwise go to PRESENT.
- STREAM: store each arriving byte at index k. Issue base+k+1 while k+1<len; go to PRESENT when byte len-1 arrives.
- Latency: out_valid rises N+1 cycles after the pc_load cycle for an N-byte instruction. Reads are back-to-back with no bubbles.
- PRESENT: out_valid=1 and all out_* held stable until out_ready.
  - On acceptance with stat AOK: go to IDLE.
  - On acceptance with stat non-AOK: go to HALT.
- out_stat HLT when icode=0 (and ifun=0). Any icode 0 ifun≠0 is INS.
- pc_load in FIRST/STREAM: abort the current instruction. Discard the in-flight byte that returns next cycle. Restart at pc_in (issue in the same cycle). out_valid never pulses for the aborted instruction.
- pc_load in PRESENT without out_ready: ignored. pc_load together with out_ready: accept, then restart at pc_in as from IDLE.
- HALT: halted=1, out_valid=0, pc_load ignored; only rst exits.
- rst mid-stream: everything cleared immediately. Any read data returning after reset is ignored.
- Address arithmetic wraps modulo 2^PC_W.
- imem_rd_en is never asserted in IDLE, PRESENT or HALT.

Optional Feature:
- Macro: Y86_IMEM_BOUND_CHECK_EN.
- Defined:
  - Before each read, check the address. If it is ≥ IMEM_BYTES, no read is issued.
  - The instruction goes straight to PRESENT on the following cycle with stat ADR, len equal to the bytes collected so far (minimum 1), and collected bytes kept.
  - out_valp = out_pc + len.
- Undefined: addresses are issued unchecked and ADR is never produced.

Decomposition:
- Package y86_pkg:
  - icode constants (I_HALT … I_POPQ).
  - stat encodings (STAT_AOK/HLT/ADR/INS).
  - aligner state enum.
  - MAX_INSTR_BYTES=10.
- Sub-module y86_ilen_decode (combinational): byte0 → len[3:0], ins_err.

Test Plan:
- irmovq, memory 30 F2 0A 00 00 00 00 00 00 00 at PC 0x10, pc_load, out_ready=1 → out_valid at cycle 11. out_instr bytes as given, len 10, valp 0x1A, stat AOK; 10 consecutive reads at 0x10–0x19.
- OPq 60 23 at PC 0, with out_ready held 0 for 5 cycles → out_* stable throughout. Accepted on the ready cycle; IDLE after; no further reads until pc_load.
- halt 00 at PC 4 → out_valid at cycle 2, len 1, stat HLT. After accept, halted=1; a following pc_load produces no reads.
- Byte F0 → stat INS, len 1, halted after accept.
- jXX at 0x20 with pc_load to 0x40 on its 4th cycle → no out_valid for 0x20. Reads restart at 0x40. Late byte from 0x23 discarded; the instruction at 0x40 is assembled correctly.
- Macro on, IMEM_BYTES=16, mrmovq at PC 12 → reads at 12–15 only. out_stat ADR, len 4, valp 16. Also: rst asserted mid-STREAM → outputs 0 asynchronously.
